// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-style 8-bit computer: opcodes, T-state
// indices and the control word that the sequencer hands to the datapath.
package sap_pkg;

    localparam int NUM_T_STATES = 6;

    // Bit index of each T-state inside the one-hot ring
    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_JZ  = 4'h4;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic pc_inc;
        logic pc_out;
        logic jump;
        logic mar_in;
        logic ram_out;
        logic ir_in;
        logic ir_out;
        logic a_in;
        logic a_out;
        logic b_in;
        logic sum_out;
        logic sub;
        logic out_in;
        logic halted;
    } ctrl_word_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave):
// opcode and zero flag flow in, T-state and strobes flow out.
interface control_sequencer_if;

    logic [3:0]                         opcode;
    logic                               zero_flag;
    logic [sap_pkg::NUM_T_STATES-1:0]   t_state;
    logic                               pc_inc;
    logic                               pc_out;
    logic                               jump;
    logic                               mar_in;
    logic                               ram_out;
    logic                               ir_in;
    logic                               ir_out;
    logic                               a_in;
    logic                               a_out;
    logic                               b_in;
    logic                               sum_out;
    logic                               sub;
    logic                               out_in;
    logic                               halted;

    modport master (
        input  opcode, zero_flag,
        output t_state, pc_inc, pc_out, jump, mar_in, ram_out, ir_in, ir_out,
               a_in, a_out, b_in, sum_out, sub, out_in, halted
    );

    modport slave (
        output opcode, zero_flag,
        input  t_state, pc_inc, pc_out, jump, mar_in, ram_out, ir_in, ir_out,
               a_in, a_out, b_in, sum_out, sub, out_in, halted
    );

endinterface

// File: rtl/ring_counter.sv
// One-hot T-state ring: reset loads T1, hold empties the ring so it reads
// all-zero and stays that way until the next reset.
module ring_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hold,
    output logic [WIDTH-1:0] ring
);

    logic [WIDTH-1:0] r_ring;
    logic [WIDTH-1:0] w_shift;

    assign w_shift[0] = r_ring[WIDTH-1];

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign w_shift[gi] = r_ring[gi-1];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ring <= {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (hold) begin
            r_ring <= '0;
        end else begin
            r_ring <= w_shift;
        end
    end

    assign ring = r_ring;

endmodule

// File: rtl/control_sequencer.sv
// SAP instruction sequencer: six-state T ring plus a RUN/HALT FSM, with the
// control word decoded combinationally from registered state and opcode.
module control_sequencer
    import sap_pkg::*;
#(
    parameter int T_STATES = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    control_sequencer_if.master  bus
);

    seq_state_t          r_state;
    seq_state_t          w_state_next;
    logic [T_STATES-1:0] w_ring;
    logic                w_hold;
    ctrl_word_t          w_ctrl;

    // Emptying the ring on the HLT edge makes t_state read zero from then on
    assign w_hold = (w_state_next == ST_HALT);

    ring_counter #(
        .WIDTH (T_STATES)
    ) u_ring (
        .clock (clock),
        .reset (reset),
        .hold  (w_hold),
        .ring  (w_ring)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ctrl       = '0;
        if (!reset) begin
            case (r_state)
                ST_RUN: begin
                    if (w_ring[T1]) begin
                        w_ctrl.pc_out = 1'b1;
                        w_ctrl.mar_in = 1'b1;
                    end else if (w_ring[T2]) begin
                        w_ctrl.pc_inc = 1'b1;
                    end else if (w_ring[T3]) begin
                        w_ctrl.ram_out = 1'b1;
                        w_ctrl.ir_in   = 1'b1;
                    end else if (w_ring[T4]) begin
                        case (bus.opcode)
                            OP_LDA, OP_ADD, OP_SUB: begin
                                w_ctrl.ir_out = 1'b1;
                                w_ctrl.mar_in = 1'b1;
                            end
                            OP_JMP: begin
                                w_ctrl.ir_out = 1'b1;
                                w_ctrl.jump   = 1'b1;
                            end
                            OP_JZ: begin
                                w_ctrl.ir_out = 1'b1;
                                w_ctrl.jump   = bus.zero_flag;
                            end
                            OP_OUT: begin
                                w_ctrl.a_out  = 1'b1;
                                w_ctrl.out_in = 1'b1;
                            end
                            OP_HLT: begin
                                w_ctrl.halted = 1'b1;
                                w_state_next  = ST_HALT;
                            end
                            default: ;
                        endcase
                    end else if (w_ring[T5]) begin
                        case (bus.opcode)
                            OP_LDA: begin
                                w_ctrl.ram_out = 1'b1;
                                w_ctrl.a_in    = 1'b1;
                            end
                            OP_ADD, OP_SUB: begin
                                w_ctrl.ram_out = 1'b1;
                                w_ctrl.b_in    = 1'b1;
                            end
                            default: ;
                        endcase
                    end else if (w_ring[T6]) begin
                        case (bus.opcode)
                            OP_ADD: begin
                                w_ctrl.sum_out = 1'b1;
                                w_ctrl.a_in    = 1'b1;
                            end
                            OP_SUB: begin
                                w_ctrl.sum_out = 1'b1;
                                w_ctrl.a_in    = 1'b1;
                                w_ctrl.sub     = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_HALT: begin
                    w_ctrl.halted = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Reset forces a quiet bus even if the ring still holds a stale state
    assign bus.t_state = reset ? '0 : w_ring;
    assign bus.pc_inc  = w_ctrl.pc_inc;
    assign bus.pc_out  = w_ctrl.pc_out;
    assign bus.jump    = w_ctrl.jump;
    assign bus.mar_in  = w_ctrl.mar_in;
    assign bus.ram_out = w_ctrl.ram_out;
    assign bus.ir_in   = w_ctrl.ir_in;
    assign bus.ir_out  = w_ctrl.ir_out;
    assign bus.a_in    = w_ctrl.a_in;
    assign bus.a_out   = w_ctrl.a_out;
    assign bus.b_in    = w_ctrl.b_in;
    assign bus.sum_out = w_ctrl.sum_out;
    assign bus.sub     = w_ctrl.sub;
    assign bus.out_in  = w_ctrl.out_in;
    assign bus.halted  = w_ctrl.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-cycle expected T-state and
// strobe word are queued at drive time and compared on the falling edge.
module tb_control_sequencer;

    localparam logic [13:0] PC_INC  = 14'h0001;
    localparam logic [13:0] PC_OUT  = 14'h0002;
    localparam logic [13:0] JUMP    = 14'h0004;
    localparam logic [13:0] MAR_IN  = 14'h0008;
    localparam logic [13:0] RAM_OUT = 14'h0010;
    localparam logic [13:0] IR_IN   = 14'h0020;
    localparam logic [13:0] IR_OUT  = 14'h0040;
    localparam logic [13:0] A_IN    = 14'h0080;
    localparam logic [13:0] A_OUT   = 14'h0100;
    localparam logic [13:0] B_IN    = 14'h0200;
    localparam logic [13:0] SUM_OUT = 14'h0400;
    localparam logic [13:0] SUB     = 14'h0800;
    localparam logic [13:0] OUT_IN  = 14'h1000;
    localparam logic [13:0] HALTED  = 14'h2000;
    localparam logic [13:0] NONE    = 14'h0000;

    typedef struct {
        logic [5:0]  t;
        logic [13:0] w;
        string       nm;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic        zf;
        logic [13:0] e4;
        logic [13:0] e5;
        logic [13:0] e6;
        string       nm;
    } vec_t;

    logic clock;
    logic reset;
    int   errors;
    int   checks;
    exp_t sb[$];
    vec_t tbl[9];

    control_sequencer_if bus();

    control_sequencer #(
        .T_STATES (6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    wire [13:0] act_w = {bus.halted, bus.out_in, bus.sub, bus.sum_out, bus.b_in,
                         bus.a_out, bus.a_in, bus.ir_out, bus.ir_in, bus.ram_out,
                         bus.mar_in, bus.jump, bus.pc_out, bus.pc_inc};
    wire [4:0]  drivers = {bus.pc_out, bus.ram_out, bus.ir_out, bus.a_out, bus.sum_out};

    always @(negedge clock) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (bus.t_state !== e.t || act_w !== e.w) begin
                errors++;
                $display("FAIL %s: got t_state=%b ctrl=%h, expected t_state=%b ctrl=%h",
                         e.nm, bus.t_state, act_w, e.t, e.w);
            end else begin
                $display("ok   %s: t_state=%b ctrl=%h", e.nm, bus.t_state, act_w);
            end
            checks++;
            if ($countones(drivers) > 1 || (bus.pc_inc && bus.jump)) begin
                errors++;
                $display("FAIL bus_conflict at %s: got drivers=%b pc_inc=%b jump=%b, expected at most one driver and no pc_inc+jump",
                         e.nm, drivers, bus.pc_inc, bus.jump);
            end
        end
    end

    task automatic step(input logic [3:0] op, input logic zf, input logic rst,
                        input logic [5:0] et, input logic [13:0] ew, input string nm);
        exp_t e;
        bus.opcode    = op;
        bus.zero_flag = zf;
        reset         = rst;
        e.t  = et;
        e.w  = ew;
        e.nm = nm;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] rnd_op();
        return 4'($urandom_range(15, 0));
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(1, 0));
    endfunction

    // Fetch cycles see a random opcode and flag: decode must ignore them there
    task automatic fetch(input string nm);
        step(rnd_op(), rnd_bit(), 1'b0, 6'b000001, PC_OUT | MAR_IN, {nm, " T1"});
        step(rnd_op(), rnd_bit(), 1'b0, 6'b000010, PC_INC,          {nm, " T2"});
        step(rnd_op(), rnd_bit(), 1'b0, 6'b000100, RAM_OUT | IR_IN, {nm, " T3"});
    endtask

    task automatic run_instr(input vec_t v);
        fetch(v.nm);
        step(v.op, v.zf,      1'b0, 6'b001000, v.e4, {v.nm, " T4"});
        step(v.op, rnd_bit(), 1'b0, 6'b010000, v.e5, {v.nm, " T5"});
        step(v.op, rnd_bit(), 1'b0, 6'b100000, v.e6, {v.nm, " T6"});
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.opcode    = 4'h0;
        bus.zero_flag = 1'b0;

        tbl[0] = '{4'h0, 1'b0, IR_OUT | MAR_IN, RAM_OUT | A_IN, NONE,                  "LDA"};
        tbl[1] = '{4'h1, 1'b0, IR_OUT | MAR_IN, RAM_OUT | B_IN, SUM_OUT | A_IN,        "ADD"};
        tbl[2] = '{4'h2, 1'b1, IR_OUT | MAR_IN, RAM_OUT | B_IN, SUM_OUT | A_IN | SUB,  "SUB"};
        tbl[3] = '{4'h3, 1'b0, IR_OUT | JUMP,   NONE,           NONE,                  "JMP"};
        tbl[4] = '{4'h4, 1'b1, IR_OUT | JUMP,   NONE,           NONE,                  "JZ_z1"};
        tbl[5] = '{4'h4, 1'b0, IR_OUT,          NONE,           NONE,                  "JZ_z0"};
        tbl[6] = '{4'hE, 1'b1, A_OUT | OUT_IN,  NONE,           NONE,                  "OUT"};
        tbl[7] = '{4'h7, 1'b1, NONE,            NONE,           NONE,                  "NOP_7"};
        tbl[8] = '{4'hA, 1'b0, NONE,            NONE,           NONE,                  "NOP_A"};

        @(posedge clock);
        #1;

        // Reset held two cycles, then the first fetch begins at T1
        step(4'h0, 1'b0, 1'b1, 6'b000000, NONE, "reset c1");
        step(4'h0, 1'b0, 1'b1, 6'b000000, NONE, "reset c2");

        for (int i = 0; i < 9; i++) begin
            run_instr(tbl[i]);
        end

        // Reset during T5 of LDA: a_in must never appear, restart at T1
        fetch("LDA_rst");
        step(4'h0, rnd_bit(), 1'b0, 6'b001000, IR_OUT | MAR_IN, "LDA_rst T4");
        step(4'h0, rnd_bit(), 1'b1, 6'b000000, NONE,            "LDA_rst T5 in reset");
        run_instr(tbl[1]);

        // HLT: halted in T4, then 20 cycles of halted-only with t_state zero
        fetch("HLT");
        step(4'hF, rnd_bit(), 1'b0, 6'b001000, HALTED, "HLT T4");
        for (int i = 0; i < 20; i++) begin
            step(rnd_op(), rnd_bit(), 1'b0, 6'b000000, HALTED, $sformatf("HALT hold %0d", i));
        end
        step(rnd_op(), rnd_bit(), 1'b1, 6'b000000, NONE, "HALT reset pulse");
        run_instr(tbl[0]);
        run_instr(tbl[2]);

        @(negedge clock);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
